hazard_control_unit: RTL



---
 rtl/hazard_control_unit_pkg.sv | 16 +
 rtl/hazard_control_unit_mem_wait_timer.sv | 44 ++++
 rtl/hazard_control_unit.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/hazard_control_unit_pkg.sv
// Shared types and constants for the pipeline hazard control unit.
package hazard_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      HUNG     = 2'd2
   } hz_state_t;

   localparam int REG_ADDR_W = 5;
   localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

   // Wait counter width; wide enough for the largest WAIT_TIMEOUT (65535).
   localparam int TMR_W = 16;

endpackage

// File: rtl/hazard_control_unit_mem_wait_timer.sv
// Counts consecutive not-ready cycles of a data-memory access and flags the
// cycle on which one more not-ready cycle means the access is hung.
module mem_wait_timer
   import hazard_pkg::*;
#(
   parameter int WAIT_TIMEOUT = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic busy,
   input  logic ready,
   output logic expired
);

   localparam logic [TMR_W-1:0] LAST_C = TMR_W'(WAIT_TIMEOUT - 1);

   logic [TMR_W-1:0] cnt_r;

   // Counter: 1 on the first stalled cycle, +1 per further not-ready cycle, 0 on release.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_r <= 16'd0;
      end else if (start) begin
         cnt_r <= 16'd1;
      end else if (busy && !ready) begin
         cnt_r <= cnt_r + 16'd1;
      end else if (busy && ready) begin
         cnt_r <= 16'd0;
      end else begin
         cnt_r <= cnt_r;
      end
   end

   // Expiry only on a not-ready waiting cycle; ready on the same cycle wins.
   always_comb begin
      if (busy && !ready && (cnt_r == LAST_C)) begin
         expired = 1'b1;
      end else begin
         expired = 1'b0;
      end
   end

endmodule

// File: rtl/hazard_control_unit.sv
// Stall/flush scheduler for the 5-stage pipeline: load-use stalls, taken-branch
// flushes and data-memory wait freezes, plus a sticky hung-memory flag.
// Optional feature macro: HAZARD_PERF_CNT_EN (adds saturating perf counters).
module hazard_control_unit
   import hazard_pkg::*;
#(
   parameter int WAIT_TIMEOUT = 255,
   parameter int CNT_W        = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic                  ex_memread,
   input  logic                  ex_branch_taken,
   input  logic                  mem_memread,
   input  logic                  mem_memwrite,
   input  logic                  dmem_ready,
   output logic                  pc_write,
   output logic                  ifid_write,
   output logic                  ifid_flush,
   output logic                  idex_write,
   output logic                  idex_flush,
   output logic                  exmem_write,
   output logic                  memwb_bubble,
   output logic                  mem_timeout
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]      stall_cycles,
   output logic [CNT_W-1:0]      flush_count,
   output logic [CNT_W-1:0]      loaduse_count
`endif
);

   hz_state_t state_r;
   hz_state_t next_state_s;
   logic      memacc_s;
   logic      loaduse_s;
   logic      freeze_s;
   logic      start_s;
   logic      busy_s;
   logic      expired_s;
   logic      flush_evt_s;
   logic      lu_evt_s;

   assign memacc_s  = mem_memread | mem_memwrite;
   assign loaduse_s = ex_memread && (ex_rd != REG_ZERO) &&
                      ((ex_rd == id_rs1) || (ex_rd == id_rs2));
   assign start_s   = (state_r == RUN) && memacc_s && !dmem_ready;
   assign busy_s    = (state_r == MEM_WAIT);

   mem_wait_timer #(
      .WAIT_TIMEOUT (WAIT_TIMEOUT)
   ) u_timer (
      .clk     (clk),
      .reset   (reset),
      .start   (start_s),
      .busy    (busy_s),
      .ready   (dmem_ready),
      .expired (expired_s)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= RUN;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Sticky hung flag; only reset clears it.
   always_ff @(posedge clk) begin
      if (reset) begin
         mem_timeout <= 1'b0;
      end else if (expired_s) begin
         mem_timeout <= 1'b1;
      end else begin
         mem_timeout <= mem_timeout;
      end
   end

   // Next state and freeze decision.
   always_comb begin
      next_state_s = state_r;
      freeze_s     = 1'b0;
      case (state_r)
         RUN: begin
            if (memacc_s && !dmem_ready) begin
               freeze_s     = 1'b1;
               next_state_s = MEM_WAIT;
            end else begin
               freeze_s     = 1'b0;
               next_state_s = RUN;
            end
         end
         MEM_WAIT: begin
            if (dmem_ready) begin
               freeze_s     = 1'b0;
               next_state_s = RUN;
            end else if (expired_s) begin
               freeze_s     = 1'b1;
               next_state_s = HUNG;
            end else begin
               freeze_s     = 1'b1;
               next_state_s = MEM_WAIT;
            end
         end
         HUNG: begin
            freeze_s     = 1'b1;
            next_state_s = HUNG;
         end
         default: begin
            freeze_s     = 1'b0;
            next_state_s = RUN;
         end
      endcase
   end

   // Pipeline controls: reset > memory freeze > branch flush > load-use stall.
   always_comb begin
      pc_write     = 1'b1;
      ifid_write   = 1'b1;
      ifid_flush   = 1'b0;
      idex_write   = 1'b1;
      idex_flush   = 1'b0;
      exmem_write  = 1'b1;
      memwb_bubble = 1'b0;
      flush_evt_s  = 1'b0;
      lu_evt_s     = 1'b0;
      if (reset) begin
         pc_write     = 1'b0;
         ifid_write   = 1'b0;
         idex_write   = 1'b0;
         exmem_write  = 1'b0;
         ifid_flush   = 1'b1;
         idex_flush   = 1'b1;
         memwb_bubble = 1'b1;
      end else if (freeze_s) begin
         pc_write     = 1'b0;
         ifid_write   = 1'b0;
         idex_write   = 1'b0;
         exmem_write  = 1'b0;
         memwb_bubble = 1'b1;
      end else if (ex_branch_taken) begin
         // The ID instruction is wrong-path, so any load-use on it is moot.
         ifid_flush  = 1'b1;
         idex_flush  = 1'b1;
         flush_evt_s = 1'b1;
      end else if (loaduse_s) begin
         pc_write   = 1'b0;
         ifid_write = 1'b0;
         idex_flush = 1'b1;
         lu_evt_s   = 1'b1;
      end else begin
         pc_write   = 1'b1;
         ifid_write = 1'b1;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   // Saturating performance counters, idle while reset is high.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cycles  <= {CNT_W{1'b0}};
         flush_count   <= {CNT_W{1'b0}};
         loaduse_count <= {CNT_W{1'b0}};
      end else begin
         if (!pc_write && (stall_cycles != CNT_MAX)) begin
            stall_cycles <= stall_cycles + CNT_ONE;
         end else begin
            stall_cycles <= stall_cycles;
         end
         if (flush_evt_s && (flush_count != CNT_MAX)) begin
            flush_count <= flush_count + CNT_ONE;
         end else begin
            flush_count <= flush_count;
         end
         if (lu_evt_s && (loaduse_count != CNT_MAX)) begin
            loaduse_count <= loaduse_count + CNT_ONE;
         end else begin
            loaduse_count <= loaduse_count;
         end
      end
   end
`else
   logic unused_perf_s;
   assign unused_perf_s = (CNT_W > 0) & flush_evt_s & lu_evt_s;
`endif

endmodule
